vscale_htif_host: RTL and testbench
===================================

VSCALE_HTIF_HOST -- requirements
Module: vscale_htif_host

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 1024, cycles allowed in REQ+WAIT before abort; 0 disables timeout; range 0..65535.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: cmd_valid  input  1  host command present.
REQ-005 Port: cmd_ready  output  1  block accepts command.
REQ-006 Port: cmd_rw  input  1  1=PCR write, 0=PCR read.
REQ-007 Port: cmd_addr  input  `CSR_ADDR_WIDTH  target CSR address.
REQ-008 Port: cmd_wdata  input  `HTIF_PCR_WIDTH  write data; ignored for reads.
REQ-009 Port: rsp_valid  output  1  result available to host.
REQ-010 Port: rsp_ready  input  1  host consumes result.
REQ-011 Port: rsp_data  output  `HTIF_PCR_WIDTH  data returned by core; 0 on timeout.
REQ-012 Port: rsp_timeout  output  1  result is a timeout abort; qualified by rsp_valid.
REQ-013 Port: htif_pcr_req_valid / _ready / _rw / _addr / _data  out/in/out/out/out  1/1/1/`CSR_ADDR_WIDTH/`HTIF_PCR_WIDTH  PCR request channel to core.
REQ-014 Port: htif_pcr_resp_valid / _ready / _data  in/out/in  1/1/`HTIF_PCR_WIDTH  PCR response channel from core.
REQ-015 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, RSP; exactly one active.
REQ-017 IDLE: cmd_ready=1; on cmd_valid capture rw/addr/wdata into internal registers, clear timeout counter, go REQ next cycle.
REQ-018 REQ: htif_pcr_req_valid=1 with _rw/_addr/_data driven from captured registers, stable until handshake; on htif_pcr_req_ready go WAIT.
REQ-019 WAIT: htif_pcr_resp_ready=1; on htif_pcr_resp_valid capture htif_pcr_resp_data into rsp_data, rsp_timeout<=0, go RSP.
REQ-020 Both reads and writes SHALL wait for a PCR response before RSP.
REQ-021 RSP: rsp_valid=1, rsp_data/rsp_timeout stable; on rsp_ready go IDLE; no new command accepted same cycle (cmd_ready=0 outside IDLE).
REQ-022 Minimum latency cmd accept -> rsp_valid: 3 cycles when core ready/valid return immediately.
REQ-023 Timeout counter (16 bits) SHALL increment each cycle in REQ or WAIT, saturating; when TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1 without handshake, next state RSP with rsp_timeout=1, rsp_data=0.
REQ-024 Simultaneous handshake and timeout expiry in the same cycle: handshake SHALL win (normal transition).
REQ-025 Timeout in REQ SHALL drop htif_pcr_req_valid next cycle.
REQ-026 htif_pcr_resp_ready SHALL also be 1 in IDLE and RSP; responses arriving there (late, after timeout) are discarded and do not alter rsp_data or state.
REQ-027 htif_pcr_req_valid SHALL be 0 in IDLE, WAIT, RSP.
REQ-028 Captured command registers update only on IDLE accept.

Reset
REQ-029 On reset: state IDLE, cmd_ready=1 from first post-reset cycle, rsp_valid=0, rsp_timeout=0, rsp_data=0, htif_pcr_req_valid=0, busy=0, counter=0, captured registers=0.
REQ-030 Reset asserted mid-transaction (any state) SHALL abandon it; no response is produced for the abandoned command.
REQ-031 Reset has priority over all handshakes in the same cycle.

Verification
REQ-032 Read: cmd rw=0 addr=0x780, core req_ready=1 immediately, resp data 0x1234 one cycle later -> rsp_valid with rsp_data=0x1234, rsp_timeout=0, 3 cycles after accept.
REQ-033 Write with backpressure: rw=1 addr=0x51E wdata=0xDEAD, req_ready low 5 cycles -> req_valid/addr/data stable all 5 cycles, then WAIT; single req handshake observed.
REQ-034 Timeout: TIMEOUT_CYCLES=8, core never asserts resp_valid -> rsp_valid with rsp_timeout=1, rsp_data=0; late resp_valid in IDLE absorbed, no second rsp_valid.
REQ-035 Boundary: resp_valid on exact expiry cycle with data 0x55 -> rsp_timeout=0, rsp_data=0x55.
REQ-036 Host stall: rsp_ready low 10 cycles -> rsp_valid/rsp_data held, cmd_ready=0; new cmd_valid ignored until IDLE.
REQ-037 Reset in WAIT -> next cycle IDLE, all outputs at reset values, no rsp_valid for abandoned command.

Source files
------------

// File: rtl/vscale_htif_host.sv
// HTIF host bridge: takes one host command at a time, issues it on the core's PCR request
// channel, waits for the PCR response (or a timeout abort) and hands the result back.

`ifndef CSR_ADDR_WIDTH
`define CSR_ADDR_WIDTH 12
`endif
`ifndef HTIF_PCR_WIDTH
`define HTIF_PCR_WIDTH 64
`endif

module vscale_htif_host #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_rw,
    input  logic [`CSR_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [`HTIF_PCR_WIDTH-1:0] cmd_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [`HTIF_PCR_WIDTH-1:0] rsp_data,
    output logic                       rsp_timeout,
    output logic                       htif_pcr_req_valid,
    input  logic                       htif_pcr_req_ready,
    output logic                       htif_pcr_req_rw,
    output logic [`CSR_ADDR_WIDTH-1:0] htif_pcr_req_addr,
    output logic [`HTIF_PCR_WIDTH-1:0] htif_pcr_req_data,
    input  logic                       htif_pcr_resp_valid,
    output logic                       htif_pcr_resp_ready,
    input  logic [`HTIF_PCR_WIDTH-1:0] htif_pcr_resp_data,
    output logic                       busy
);
    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

    state_t                       r_state;
    state_t                       w_next_state;
    logic                         r_rw;
    logic [`CSR_ADDR_WIDTH-1:0]   r_addr;
    logic [`HTIF_PCR_WIDTH-1:0]   r_wdata;
    logic [15:0]                  r_count;
    logic [`HTIF_PCR_WIDTH-1:0]   r_rsp_data;
    logic                         r_rsp_timeout;
    logic                         w_accept;
    logic                         w_resp_take;
    logic                         w_abort;
    logic                         w_expire;

    // Expiry only matters when no handshake happens that cycle; the handshake branches win.
    assign w_expire = TIMEOUT_EN && (r_count == TIMEOUT_LAST);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_next_state        = r_state;
        w_accept            = 1'b0;
        w_resp_take         = 1'b0;
        w_abort             = 1'b0;
        cmd_ready           = 1'b0;
        htif_pcr_req_valid  = 1'b0;
        htif_pcr_resp_ready = 1'b1;
        rsp_valid           = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = REQ;
                end
            end
            REQ: begin
                htif_pcr_req_valid  = 1'b1;
                htif_pcr_resp_ready = 1'b0;
                if (htif_pcr_req_ready) begin
                    w_next_state = WAIT;
                end else if (w_expire) begin
                    w_abort      = 1'b1;
                    w_next_state = RSP;
                end
            end
            WAIT: begin
                if (htif_pcr_resp_valid) begin
                    w_resp_take  = 1'b1;
                    w_next_state = RSP;
                end else if (w_expire) begin
                    w_abort      = 1'b1;
                    w_next_state = RSP;
                end
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rw          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_count       <= '0;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rw    <= cmd_rw;
                r_addr  <= cmd_addr;
                r_wdata <= cmd_wdata;
                r_count <= '0;
            end else if ((r_state == REQ || r_state == WAIT) && (r_count != 16'hFFFF)) begin
                r_count <= r_count + 16'd1;
            end
            if (w_resp_take) begin
                r_rsp_data    <= htif_pcr_resp_data;
                r_rsp_timeout <= 1'b0;
            end else if (w_abort) begin
                r_rsp_data    <= '0;
                r_rsp_timeout <= 1'b1;
            end
        end
    end

    assign htif_pcr_req_rw   = r_rw;
    assign htif_pcr_req_addr = r_addr;
    assign htif_pcr_req_data = r_wdata;
    assign rsp_data          = r_rsp_data;
    assign rsp_timeout       = r_rsp_timeout;
    assign busy              = (r_state != IDLE);

endmodule

// File: tb/tb_vscale_htif_host.sv
// Directed bench for vscale_htif_host with an 8-cycle timeout: read, backpressured write,
// host stall, timeouts in REQ and WAIT, expiry-cycle boundary and reset mid-transaction.
`timescale 1ns/1ps

`ifndef CSR_ADDR_WIDTH
`define CSR_ADDR_WIDTH 12
`endif
`ifndef HTIF_PCR_WIDTH
`define HTIF_PCR_WIDTH 64
`endif

module tb_vscale_htif_host;
    logic                       clk;
    logic                       reset;
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic                       cmd_rw;
    logic [`CSR_ADDR_WIDTH-1:0] cmd_addr;
    logic [`HTIF_PCR_WIDTH-1:0] cmd_wdata;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [`HTIF_PCR_WIDTH-1:0] rsp_data;
    logic                       rsp_timeout;
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_rw;
    logic [`CSR_ADDR_WIDTH-1:0] req_addr;
    logic [`HTIF_PCR_WIDTH-1:0] req_data;
    logic                       resp_valid;
    logic                       resp_ready;
    logic [`HTIF_PCR_WIDTH-1:0] resp_data;
    logic                       busy;

    int n_checks = 0;
    int n_errors = 0;
    int hs_count = 0;
    int hs_base;

    vscale_htif_host #(.TIMEOUT_CYCLES(8)) dut (
        .clk                 (clk),
        .reset               (reset),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_rw              (cmd_rw),
        .cmd_addr            (cmd_addr),
        .cmd_wdata           (cmd_wdata),
        .rsp_valid           (rsp_valid),
        .rsp_ready           (rsp_ready),
        .rsp_data            (rsp_data),
        .rsp_timeout         (rsp_timeout),
        .htif_pcr_req_valid  (req_valid),
        .htif_pcr_req_ready  (req_ready),
        .htif_pcr_req_rw     (req_rw),
        .htif_pcr_req_addr   (req_addr),
        .htif_pcr_req_data   (req_data),
        .htif_pcr_resp_valid (resp_valid),
        .htif_pcr_resp_ready (resp_ready),
        .htif_pcr_resp_data  (resp_data),
        .busy                (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (req_valid && req_ready) hs_count <= hs_count + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
        tick(); tick();
        check_bit("rst_cmd_ready", cmd_ready, 1'b1);
        check_bit("rst_rsp_valid", rsp_valid, 1'b0);
        check_bit("rst_rsp_timeout", rsp_timeout, 1'b0);
        check("rst_rsp_data", rsp_data, 64'h0);
        check_bit("rst_req_valid", req_valid, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check("rst_req_addr", 64'(req_addr), 64'h0);
        check("rst_req_data", req_data, 64'h0);
        reset = 1'b0;

        // Read with immediate core handshakes: rsp_valid three cycles after accept.
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 12'h780; cmd_wdata = 64'hFFFF; req_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check_bit("rd_req_valid", req_valid, 1'b1);
        check_bit("rd_req_rw", req_rw, 1'b0);
        check("rd_req_addr", 64'(req_addr), 64'h780);
        check_bit("rd_cmd_ready_busy", cmd_ready, 1'b0);
        check_bit("rd_busy", busy, 1'b1);
        tick();
        req_ready = 1'b0;
        check_bit("rd_wait_req_valid", req_valid, 1'b0);
        check_bit("rd_wait_resp_ready", resp_ready, 1'b1);
        check_bit("rd_wait_rsp_valid", rsp_valid, 1'b0);
        resp_valid = 1'b1; resp_data = 64'h1234;
        tick();
        resp_valid = 1'b0;
        check_bit("rd_rsp_valid", rsp_valid, 1'b1);
        check("rd_rsp_data", rsp_data, 64'h1234);
        check_bit("rd_rsp_timeout", rsp_timeout, 1'b0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_bit("rd_back_idle", cmd_ready, 1'b1);
        check_bit("rd_rsp_dropped", rsp_valid, 1'b0);

        // Write with 5 cycles of request backpressure; inputs change but the request must not.
        hs_base = hs_count;
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 12'h51E; cmd_wdata = 64'hDEAD; req_ready = 1'b0;
        tick();
        cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 12'h111; cmd_wdata = 64'h0;
        for (int i = 0; i < 5; i++) begin
            check_bit("wr_bp_req_valid", req_valid, 1'b1);
            check_bit("wr_bp_req_rw", req_rw, 1'b1);
            check("wr_bp_req_addr", 64'(req_addr), 64'h51E);
            check("wr_bp_req_data", req_data, 64'hDEAD);
            tick();
        end
        req_ready = 1'b1;
        check_bit("wr_req_valid_at_hs", req_valid, 1'b1);
        tick();
        req_ready = 1'b0;
        check_bit("wr_wait_req_valid", req_valid, 1'b0);
        check_bit("wr_wait_busy", busy, 1'b1);
        check_bit("wr_wait_rsp_valid", rsp_valid, 1'b0);
        resp_valid = 1'b1; resp_data = 64'h77;
        tick();
        check_bit("wr_rsp_valid", rsp_valid, 1'b1);
        check("wr_rsp_data", rsp_data, 64'h77);
        check_bit("wr_rsp_timeout", rsp_timeout, 1'b0);
        check("wr_single_handshake", 64'(hs_count - hs_base), 64'd1);

        // Host stall in RSP: a new command and a stray core response must both be ignored.
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 12'h3C3; cmd_wdata = 64'h5;
        resp_valid = 1'b1; resp_data = 64'hBAD;
        for (int i = 0; i < 10; i++) begin
            check_bit("stall_rsp_valid", rsp_valid, 1'b1);
            check("stall_rsp_data", rsp_data, 64'h77);
            check_bit("stall_cmd_ready", cmd_ready, 1'b0);
            tick();
        end
        cmd_valid = 1'b0; resp_valid = 1'b0; rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_bit("stall_back_idle", cmd_ready, 1'b1);
        check("stall_cmd_not_captured", 64'(req_addr), 64'h51E);
        tick();
        check_bit("stall_idle_not_busy", busy, 1'b0);

        // Timeout in WAIT: 1 REQ cycle + 7 WAIT cycles, then a timeout result.
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 12'h300; req_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        req_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check_bit("to_wait_no_rsp", rsp_valid, 1'b0);
            check_bit("to_wait_busy", busy, 1'b1);
            tick();
        end
        check_bit("to_rsp_valid", rsp_valid, 1'b1);
        check_bit("to_rsp_timeout", rsp_timeout, 1'b1);
        check("to_rsp_data", rsp_data, 64'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        resp_valid = 1'b1; resp_data = 64'h99;
        tick();
        resp_valid = 1'b0;
        check_bit("late_resp_idle", cmd_ready, 1'b1);
        check_bit("late_resp_not_busy", busy, 1'b0);
        check("late_resp_data_kept", rsp_data, 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_bit("late_resp_no_rsp", rsp_valid, 1'b0);
        end

        // Timeout in REQ: request stays up 8 cycles, then drops as RSP reports the abort.
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 12'h7C0; cmd_wdata = 64'hA5; req_ready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_bit("to_req_valid_held", req_valid, 1'b1);
            tick();
        end
        check_bit("to_req_valid_dropped", req_valid, 1'b0);
        check_bit("to_req_rsp_valid", rsp_valid, 1'b1);
        check_bit("to_req_rsp_timeout", rsp_timeout, 1'b1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Response on the exact expiry cycle wins over the timeout.
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 12'h781; req_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        req_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check_bit("edge_still_waiting", rsp_valid, 1'b0);
        resp_valid = 1'b1; resp_data = 64'h55;
        tick();
        resp_valid = 1'b0;
        check_bit("edge_rsp_valid", rsp_valid, 1'b1);
        check_bit("edge_rsp_timeout", rsp_timeout, 1'b0);
        check("edge_rsp_data", rsp_data, 64'h55);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset in WAIT, coincident with a core response: reset wins, command is abandoned.
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 12'h123; cmd_wdata = 64'h42; req_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        req_ready = 1'b0;
        check_bit("rw_in_wait_busy", busy, 1'b1);
        reset = 1'b1; resp_valid = 1'b1; resp_data = 64'hEE;
        tick();
        reset = 1'b0; resp_valid = 1'b0;
        check_bit("rw_cmd_ready", cmd_ready, 1'b1);
        check_bit("rw_busy", busy, 1'b0);
        check_bit("rw_rsp_valid", rsp_valid, 1'b0);
        check_bit("rw_rsp_timeout", rsp_timeout, 1'b0);
        check("rw_rsp_data", rsp_data, 64'h0);
        check_bit("rw_req_valid", req_valid, 1'b0);
        check("rw_req_addr", 64'(req_addr), 64'h0);
        check("rw_req_data", req_data, 64'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_bit("rw_no_rsp", rsp_valid, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
